astro_rom_loader: RTL and testbench

Sits between the HPS download stream and the 8-bit cartridge and BIOS ROM dpram instances. It takes 16-bit ioctl words and splits each into two byte writes, holding the HPS off with `ioctl_wait` while it does so. It routes writes by `ioctl_index`, tracks the loaded cartridge size, and derives a power-of-two mirror mask. It also mirrors the CPU cartridge read address so that 2K/4K carts alias correctly across the 8K window.

---
 rtl/astro_pkg.sv | 33 +++
 rtl/astro_edge_det.sv | 29 ++
 rtl/astro_rom_loader.sv | 182 ++++++++++++++++++
 tb/tb_astro_rom_loader.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/astro_pkg.sv
// Shared types and helpers for the Astrocade ROM loader.
package astro_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WR_LO  = 2'd1,
      WR_HI  = 2'd2,
      FINISH = 2'd3
   } loader_state_t;

   localparam logic [7:0] IDX_BIOS_DEF = 8'd0;
   localparam logic [7:0] IDX_CART_DEF = 8'd1;

   // Smallest 2^k >= size, minus one, clamped to the 2^width window; size 0 maps to the full window.
   function automatic logic [31:0] pow2_mask(input logic [15:0] size, input int unsigned width);
      logic [31:0] full;
      logic [31:0] m;
      full = (32'd1 << width) - 32'd1;
      m    = full;
      if (size != 16'd0) begin
         for (int k = 16; k >= 0; k--) begin
            if ((32'd1 << k) >= {16'd0, size}) begin
               m = (32'd1 << k) - 32'd1;
            end
         end
         if (m > full) begin
            m = full;
         end
      end
      return m;
   endfunction

endpackage

// File: rtl/astro_edge_det.sv
// Registered rising/falling edge detector; each output is a one-cycle pulse.
module astro_edge_det (
   input  logic clk_sys,
   input  logic reset_l,
   input  logic sig_i,
   output logic rise_o,
   output logic fall_o
);

   logic prev_q;
   logic rise_q;
   logic fall_q;

   always_ff @(posedge clk_sys or negedge reset_l) begin
      if (!reset_l) begin
         prev_q <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         prev_q <= sig_i;
         rise_q <= sig_i & ~prev_q;
         fall_q <= ~sig_i & prev_q;
      end
   end

   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/astro_rom_loader.sv
// Splits HPS ioctl words into BIOS/cartridge ROM byte writes, tracks cart size and
// mirrors cart reads. Define ASTRO_CART_MIRROR_EN to enable power-of-two read mirroring.
module astro_rom_loader
   import astro_pkg::*;
#(
   parameter int         ADDR_W   = 13,
   parameter logic [7:0] IDX_BIOS = IDX_BIOS_DEF,
   parameter logic [7:0] IDX_CART = IDX_CART_DEF
) (
   input  logic              clk_sys,
   input  logic              reset_l,
   input  logic              ioctl_download,
   input  logic [7:0]        ioctl_index,
   input  logic              ioctl_wr,
   input  logic [24:0]       ioctl_addr,
   input  logic [15:0]       ioctl_dout,
   output logic              ioctl_wait,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_data,
   output logic              cart_we,
   output logic              bios_we,
   input  logic [ADDR_W-1:0] cpu_cart_addr,
   output logic [ADDR_W-1:0] cart_rd_addr,
   output logic [15:0]       cart_size,
   output logic              load_done,
   output logic              overflow
);

   localparam logic [24:0] WIN_END = 25'(1) << ADDR_W;

   loader_state_t     state_q, state_d;
   logic [7:0]        hi_q, hi_d;
   logic [24:0]       addr_q, addr_d;
   logic [7:0]        idx_q, idx_d;
   logic              fin_pend_q, fin_pend_d;
   logic              wait_q, wait_d;
   logic              cart_we_q, cart_we_d;
   logic              bios_we_q, bios_we_d;
   logic              done_q, done_d;
   logic              ovf_q, ovf_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [7:0]        mem_data_q, mem_data_d;
   logic [ADDR_W-1:0] mask_q, mask_d;
   logic [15:0]       size_q, size_d;

   logic              dl_rise, dl_fall;
   logic              cart_sel, dl_clear, fin_req;
   logic [15:0]       size_base, size_cand;
   logic [25:0]       size_sum;
   logic [24:0]       hi_addr;

   astro_edge_det u_dl_edge (
      .clk_sys (clk_sys),
      .reset_l (reset_l),
      .sig_i   (ioctl_download),
      .rise_o  (dl_rise),
      .fall_o  (dl_fall)
   );

   assign cart_sel  = (ioctl_index == IDX_CART);
   assign dl_clear  = dl_rise & cart_sel;
   assign fin_req   = dl_fall & cart_sel;
   assign size_sum  = {1'b0, ioctl_addr} + 26'd2;
   assign size_cand = (size_sum > 26'h00_FFFF) ? 16'hFFFF : size_sum[15:0];
   assign size_base = dl_clear ? 16'd0 : size_q;
   assign hi_addr   = addr_q + 25'd1;

   always_comb begin
      state_d    = state_q;
      hi_d       = hi_q;
      addr_d     = addr_q;
      idx_d      = idx_q;
      fin_pend_d = fin_pend_q | fin_req;
      wait_d     = 1'b0;
      cart_we_d  = 1'b0;
      bios_we_d  = 1'b0;
      done_d     = 1'b0;
      ovf_d      = ovf_q & ~dl_clear;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      mask_d     = mask_q;
      size_d     = size_base;

      unique case (state_q)
         IDLE: begin
            if (fin_pend_d) begin
               state_d = FINISH;
            end else if (ioctl_wr && ioctl_download) begin
               state_d    = WR_LO;
               hi_d       = ioctl_dout[15:8];
               addr_d     = ioctl_addr;
               idx_d      = ioctl_index;
               wait_d     = 1'b1;
               mem_addr_d = ioctl_addr[ADDR_W-1:0];
               mem_data_d = ioctl_dout[7:0];
               if (ioctl_addr < WIN_END) begin
                  cart_we_d = (ioctl_index == IDX_CART);
                  bios_we_d = (ioctl_index == IDX_BIOS);
               end else begin
                  ovf_d = 1'b1;
               end
               if (cart_sel && (size_cand > size_base)) begin
                  size_d = size_cand;
               end
            end
         end
         WR_LO: begin
            state_d    = WR_HI;
            wait_d     = 1'b1;
            mem_addr_d = hi_addr[ADDR_W-1:0];
            mem_data_d = hi_q;
            if (hi_addr < WIN_END) begin
               cart_we_d = (idx_q == IDX_CART);
               bios_we_d = (idx_q == IDX_BIOS);
            end else begin
               ovf_d = 1'b1;
            end
         end
         WR_HI: begin
            // A download that ended mid-word finishes only after the high byte is out.
            state_d = fin_pend_d ? FINISH : IDLE;
         end
         FINISH: begin
            state_d    = IDLE;
            done_d     = 1'b1;
            fin_pend_d = 1'b0;
`ifdef ASTRO_CART_MIRROR_EN
            mask_d     = ADDR_W'(pow2_mask(size_q, ADDR_W));
`else
            mask_d     = '1;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_l) begin
      if (!reset_l) begin
         state_q    <= IDLE;
         hi_q       <= 8'd0;
         addr_q     <= 25'd0;
         idx_q      <= 8'd0;
         fin_pend_q <= 1'b0;
         wait_q     <= 1'b0;
         cart_we_q  <= 1'b0;
         bios_we_q  <= 1'b0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
         mem_addr_q <= '0;
         mem_data_q <= 8'd0;
         mask_q     <= '1;
         size_q     <= 16'd0;
      end else begin
         state_q    <= state_d;
         hi_q       <= hi_d;
         addr_q     <= addr_d;
         idx_q      <= idx_d;
         fin_pend_q <= fin_pend_d;
         wait_q     <= wait_d;
         cart_we_q  <= cart_we_d;
         bios_we_q  <= bios_we_d;
         done_q     <= done_d;
         ovf_q      <= ovf_d;
         mem_addr_q <= mem_addr_d;
         mem_data_q <= mem_data_d;
         mask_q     <= mask_d;
         size_q     <= size_d;
      end
   end

   assign ioctl_wait   = wait_q;
   assign cart_we      = cart_we_q;
   assign bios_we      = bios_we_q;
   assign load_done    = done_q;
   assign overflow     = ovf_q;
   assign mem_addr     = mem_addr_q;
   assign mem_data     = mem_data_q;
   assign cart_size    = size_q;
   // mask_q is a register, so this AND cannot glitch on a mask change.
   assign cart_rd_addr = cpu_cart_addr & mask_q;

endmodule

// File: tb/tb_astro_rom_loader.sv
// Randomized self-checking bench for astro_rom_loader against a byte-level memory/size model.
module tb_astro_rom_loader;

   localparam int          AW    = 13;
   localparam int unsigned WIN   = 8192;
   localparam logic [7:0]  IDX_B = 8'd0;
   localparam logic [7:0]  IDX_C = 8'd1;

   logic          clk_sys = 1'b0;
   logic          reset_l = 1'b1;
   logic          ioctl_download = 1'b0;
   logic [7:0]    ioctl_index = 8'd0;
   logic          ioctl_wr = 1'b0;
   logic [24:0]   ioctl_addr = 25'd0;
   logic [15:0]   ioctl_dout = 16'd0;
   logic          ioctl_wait;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_data;
   logic          cart_we;
   logic          bios_we;
   logic [AW-1:0] cpu_cart_addr = '0;
   logic [AW-1:0] cart_rd_addr;
   logic [15:0]   cart_size;
   logic          load_done;
   logic          overflow;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit [7:0]    exp_cart [WIN];
   bit [7:0]    exp_bios [WIN];
   bit          exp_cart_wr [WIN];
   bit          exp_bios_wr [WIN];
   int          exp_cart_cnt = 0;
   int          exp_bios_cnt = 0;
   logic [15:0] m_size = 16'd0;
   logic        m_ovf  = 1'b0;
   logic [12:0] m_mask = '1;

   // Observed ROM contents
   bit [7:0]    dut_cart [WIN];
   bit [7:0]    dut_bios [WIN];
   bit          dut_cart_wr [WIN];
   bit          dut_bios_wr [WIN];
   int          cart_wr_cnt = 0;
   int          bios_wr_cnt = 0;

   astro_rom_loader dut (
      .clk_sys        (clk_sys),
      .reset_l        (reset_l),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_wait     (ioctl_wait),
      .mem_addr       (mem_addr),
      .mem_data       (mem_data),
      .cart_we        (cart_we),
      .bios_we        (bios_we),
      .cpu_cart_addr  (cpu_cart_addr),
      .cart_rd_addr   (cart_rd_addr),
      .cart_size      (cart_size),
      .load_done      (load_done),
      .overflow       (overflow)
   );

   always #5 clk_sys = ~clk_sys;

   // A write enable seen mid-cycle is committed to the ROM on the following rising edge.
   always @(negedge clk_sys) begin
      if (cart_we) begin
         dut_cart[mem_addr]    <= mem_data;
         dut_cart_wr[mem_addr] <= 1'b1;
         cart_wr_cnt           <= cart_wr_cnt + 1;
      end
      if (bios_we) begin
         dut_bios[mem_addr]    <= mem_data;
         dut_bios_wr[mem_addr] <= 1'b1;
         bios_wr_cnt           <= bios_wr_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [12:0] exp_mask(input logic [15:0] sz);
      logic [12:0] m;
      int k;
      if (sz == 16'd0) begin
         m = '1;
      end else begin
         k = $clog2(sz);
         m = (k >= AW) ? 13'h1FFF : 13'((32'd1 << k) - 32'd1);
      end
`ifndef ASTRO_CART_MIRROR_EN
      m = '1;
`endif
      return m;
   endfunction

   task automatic model_word(input logic [7:0] idx, input logic [24:0] a, input logic [15:0] d);
      int unsigned ba;
      int unsigned top;
      for (int b = 0; b < 2; b++) begin
         ba = 32'(a) + 32'(b);
         if (ba >= WIN) begin
            m_ovf = 1'b1;
         end else if (idx == IDX_C) begin
            exp_cart[ba] = d[8*b +: 8];
            exp_cart_wr[ba] = 1'b1;
            exp_cart_cnt++;
         end else if (idx == IDX_B) begin
            exp_bios[ba] = d[8*b +: 8];
            exp_bios_wr[ba] = 1'b1;
            exp_bios_cnt++;
         end
      end
      if (idx == IDX_C) begin
         top = 32'(a) + 32'd2;
         if (top > 32'hFFFF) top = 32'hFFFF;
         if (top > 32'(m_size)) m_size = 16'(top);
      end
   endtask

   // Called on a falling edge; returns on the falling edge where the next strobe may be driven.
   task automatic wr_word(input logic [7:0] idx, input logic [24:0] a, input logic [15:0] d,
                          input bit detail);
      int unsigned ba;
      logic [7:0]  bv;
      bit          in_win;
      model_word(idx, a, d);
      ioctl_index = idx;
      ioctl_addr  = a;
      ioctl_dout  = d;
      ioctl_wr    = 1'b1;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      for (int b = 0; b < 2; b++) begin
         if (detail) begin
            ba     = 32'(a) + 32'(b);
            bv     = (b == 0) ? d[7:0] : d[15:8];
            in_win = (ba < WIN);
            chk("wait_busy", ioctl_wait, 1'b1);
            chk("cart_we", cart_we, in_win && (idx == IDX_C));
            chk("bios_we", bios_we, in_win && (idx == IDX_B));
            if (in_win && (idx == IDX_C || idx == IDX_B)) begin
               chk("mem_addr", mem_addr, ba[12:0]);
               chk("mem_data", mem_data, bv);
            end
         end
         @(negedge clk_sys);
      end
      if (detail) begin
         chk("wait_free", ioctl_wait, 1'b0);
         chk("we_idle", cart_we | bios_we, 1'b0);
      end
   endtask

   task automatic load_range(input logic [7:0] idx, input int unsigned base, input int unsigned n);
      for (int unsigned a = base; a < base + n; a += 2) begin
         wr_word(idx, 25'(a), 16'($urandom), (a & 32'h1FE) == 0);
      end
      $display("load idx=%0d base=%h bytes=%h cart_size=%h", idx, base, n, cart_size);
   endtask

   task automatic dl_start(input logic [7:0] idx);
      ioctl_index    = idx;
      ioctl_download = 1'b1;
      if (idx == IDX_C) begin
         m_size = 16'd0;
         m_ovf  = 1'b0;
      end
      repeat (3) @(negedge clk_sys);
   endtask

   task automatic dl_end(input logic [7:0] idx);
      int          pulses;
      int          first;
      logic [12:0] nm;
      logic [12:0] probe;
      bit          is_cart;
      is_cart = (idx == IDX_C);
      nm      = is_cart ? exp_mask(m_size) : m_mask;
      probe   = 13'($urandom);
      cpu_cart_addr  = probe;
      pulses  = 0;
      first   = -1;
      ioctl_index    = idx;
      ioctl_download = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk_sys);
         if (load_done) begin
            if (first < 0) first = c;
            pulses++;
            chk("rd_at_done", cart_rd_addr, probe & nm);
         end
      end
      chk("done_pulses", pulses, is_cart ? 1 : 0);
      if (is_cart) begin
         chk("done_latency_ge2", first >= 2, 1'b1);
         m_mask = nm;
      end
      chk("rd_after_end", cart_rd_addr, probe & m_mask);
      $display("download end idx=%0d pulses=%0d cart_size=%h", idx, pulses, cart_size);
   endtask

   task automatic cmp_mem(input string tag);
      int bad_c;
      int bad_b;
      #2;
      bad_c = 0;
      bad_b = 0;
      for (int i = 0; i < int'(WIN); i++) begin
         if (dut_cart_wr[i] != exp_cart_wr[i] || dut_cart[i] != exp_cart[i]) bad_c++;
         if (dut_bios_wr[i] != exp_bios_wr[i] || dut_bios[i] != exp_bios[i]) bad_b++;
      end
      chk({tag, "_cart_bytes_bad"}, bad_c, 0);
      chk({tag, "_bios_bytes_bad"}, bad_b, 0);
      chk({tag, "_cart_wr_cnt"}, cart_wr_cnt, exp_cart_cnt);
      chk({tag, "_bios_wr_cnt"}, bios_wr_cnt, exp_bios_cnt);
      @(negedge clk_sys);
   endtask

   task automatic chk_state(input string tag);
      chk({tag, "_size"}, cart_size, m_size);
      chk({tag, "_ovf"}, overflow, m_ovf);
   endtask

   task automatic chk_reset_vals(input string tag);
      cpu_cart_addr = 13'h1A34;
      #1;
      chk({tag, "_wait"}, ioctl_wait, 1'b0);
      chk({tag, "_we"}, {cart_we, bios_we}, 2'b00);
      chk({tag, "_done"}, load_done, 1'b0);
      chk({tag, "_ovf"}, overflow, 1'b0);
      chk({tag, "_mem_addr"}, mem_addr, 13'd0);
      chk({tag, "_mem_data"}, mem_data, 8'd0);
      chk({tag, "_size"}, cart_size, 16'd0);
      chk({tag, "_rd_full"}, cart_rd_addr, 13'h1A34);
   endtask

   initial begin
      // Reset values
      #3 reset_l = 1'b0;
      repeat (2) @(negedge clk_sys);
      chk_reset_vals("reset");
      @(negedge clk_sys);
      reset_l = 1'b1;
      @(negedge clk_sys);

      // Single cartridge word, then a strobe that arrives while busy
      dl_start(IDX_C);
      chk("wait_pre", ioctl_wait, 1'b0);
      wr_word(IDX_C, 25'h10, 16'hA55A, 1'b1);
      model_word(IDX_C, 25'h30, 16'h1234);
      ioctl_addr = 25'h30; ioctl_dout = 16'h1234; ioctl_wr = 1'b1;
      @(negedge clk_sys);
      ioctl_addr = 25'h40; ioctl_dout = 16'hBEEF;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      @(negedge clk_sys);
      chk_state("word");
      cmp_mem("word");
      dl_end(IDX_C);

      // 2K cartridge
      dl_start(IDX_C);
      load_range(IDX_C, 0, 32'h800);
      dl_end(IDX_C);
      chk_state("cart2k");
      chk("cart2k_size_lit", cart_size, 16'h0800);
      cpu_cart_addr = 13'h1A34;
      #1 chk("cart2k_rd_1A34", cart_rd_addr, 13'h1A34 & m_mask);
      cmp_mem("cart2k");

      // Odd-size cartridge
      dl_start(IDX_C);
      load_range(IDX_C, 0, 32'hC00);
      dl_end(IDX_C);
      chk_state("cartC00");
      for (int i = 0; i < 6; i++) begin
         cpu_cart_addr = (i == 0) ? 13'h1A34 : 13'($urandom);
         #1 chk("cartC00_rd", cart_rd_addr, cpu_cart_addr & m_mask);
      end
      cmp_mem("cartC00");

      // BIOS download leaves cartridge state alone
      @(negedge clk_sys);
      dl_start(IDX_B);
      chk("bios_start_size", cart_size, m_size);
      load_range(IDX_B, 0, 32'h2000);
      dl_end(IDX_B);
      chk_state("bios");
      cmp_mem("bios");

      // Window boundary, overflow, unknown index and saturation
      dl_start(IDX_C);
      wr_word(IDX_C, 25'h1FFE, 16'($urandom), 1'b1);
      chk_state("edge1FFE");
      wr_word(IDX_C, 25'h2000, 16'($urandom), 1'b1);
      chk_state("win2000");
      wr_word(8'd5, 25'h100, 16'($urandom), 1'b1);
      wr_word(IDX_C, 25'h1FF_FFFE, 16'($urandom), 1'b1);
      chk_state("sat");
      dl_end(IDX_C);
      dl_start(IDX_C);
      chk_state("restart");
      dl_end(IDX_C);
      cmp_mem("ovf");

      // Reset in the middle of a word
      dl_start(IDX_C);
      load_range(IDX_C, 0, 32'h400);
      dl_end(IDX_C);
      dl_start(IDX_C);
      wr_word(IDX_C, 25'h2000, 16'($urandom), 1'b0);
      chk_state("pre_rst");
      ioctl_addr = 25'h50; ioctl_dout = 16'($urandom); ioctl_wr = 1'b1;
      @(negedge clk_sys);
      ioctl_wr = 1'b0;
      chk("we_before_rst", cart_we, 1'b1);
      #2 reset_l = 1'b0;
      chk_reset_vals("midrst");
      @(negedge clk_sys);
      reset_l = 1'b1;
      m_size = 16'd0;
      m_ovf  = 1'b0;
      m_mask = '1;
      $display("reset mid-word released");
      repeat (3) @(negedge clk_sys);
      wr_word(IDX_C, 25'h60, 16'($urandom), 1'b1);
      chk_state("post_rst");
      dl_end(IDX_C);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
